// File: rtl/pixel_pkg.sv
// Shared types, default geometry and address helper for the pixel frame buffer.
package pixel_pkg;

    localparam int H_DEFAULT = 640;
    localparam int V_DEFAULT = 480;
    localparam int COLOUR_W  = 3;

    // Coordinate widths leave room for the value one past the last pixel,
    // so an overflowing column or row can be presented and rejected.
    localparam int XW = $clog2(H_DEFAULT + 1);
    localparam int YW = $clog2(V_DEFAULT + 1);
    localparam int AW = $clog2(H_DEFAULT * V_DEFAULT);

    typedef logic [COLOUR_W-1:0] colour_t;

    localparam colour_t BG_COLOUR = 3'b000;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic logic [31:0] pix_addr(input logic [31:0] px,
                                             input logic [31:0] py,
                                             input logic [31:0] width);
        return py * width + px;
    endfunction

endpackage

// File: rtl/pixel_framebuffer_rx_fb_ram.sv
// Frame buffer storage: one write port, one synchronous read-first read port.
module fb_ram
    import pixel_pkg::*;
#(
    parameter int depth = H_DEFAULT * V_DEFAULT,
    parameter int aw    = AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [aw-1:0] waddr,
    input  colour_t       wdata,
    input  logic          re,
    input  logic [aw-1:0] raddr,
    output colour_t       rdata
);

    colour_t mem [0:depth-1];

    // NOTE: the array has no reset; the clear sweep initialises it, and a reset
    // branch here would stop it mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // NOTE: non-blocking assignment samples mem before this edge's write lands,
    // which is what makes a same-address read return the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pixel_framebuffer_rx.sv
// Pixel-plot receiver: clears the frame buffer, captures plotted pixels and
// serves a synchronous read-back port.
module pixel_framebuffer_rx
    import pixel_pkg::*;
#(
    parameter  int horizontal = H_DEFAULT,
    parameter  int vertical   = V_DEFAULT,
    localparam int xw         = $clog2(horizontal + 1),
    localparam int yw         = $clog2(vertical + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          plot,
    input  logic [xw-1:0] x,
    input  logic [yw-1:0] y,
    input  colour_t       colour,
    input  logic          clear_req,
    output logic          ready,
    output logic          frame_done,
    input  logic          rd_en,
    input  logic [xw-1:0] rd_x,
    input  logic [yw-1:0] rd_y,
    output logic          rd_valid,
    output colour_t       rd_colour,
    output logic [15:0]   drop_cnt
);

    localparam int depth = horizontal * vertical;
    localparam int aw    = $clog2(depth);

    localparam logic [xw-1:0] x_lim     = xw'(horizontal);
    localparam logic [yw-1:0] y_lim     = yw'(vertical);
    localparam logic [xw-1:0] x_last    = xw'(horizontal - 1);
    localparam logic [yw-1:0] y_last    = yw'(vertical - 1);
    localparam logic [aw-1:0] addr_last = aw'(depth - 1);

    state_t        state;
    state_t        state_nxt;
    logic [aw-1:0] clr_addr;

    logic          wr_in_range;
    logic          rd_in_range;
    logic          accept;
    logic          drop;
    logic          rd_take;
    logic [aw-1:0] wr_addr;
    logic [aw-1:0] rd_addr;

    logic          ram_we;
    logic [aw-1:0] ram_waddr;
    colour_t       ram_wdata;

    assign wr_in_range = (x < x_lim) && (y < y_lim);
    assign rd_in_range = (rd_x < x_lim) && (rd_y < y_lim);

    // Truncation is safe: out-of-range coordinates never reach the RAM.
    assign wr_addr = aw'(pix_addr(32'(x), 32'(y), 32'(horizontal)));
    assign rd_addr = aw'(pix_addr(32'(rd_x), 32'(rd_y), 32'(horizontal)));

    assign accept  = plot && ready && wr_in_range;
    assign drop    = plot && ready && !wr_in_range;
    assign rd_take = rd_en && ready && rd_in_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= (state_nxt == RUN);
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = colour;
        case (state)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr;
                ram_wdata = BG_COLOUR;
                if (clr_addr == addr_last) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                ram_we = accept;
                if (clear_req) begin
                    state_nxt = CLEAR;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // The sweep counter restarts from zero whenever a new sweep begins.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_addr <= '0;
        end else if (state == CLEAR && state_nxt == CLEAR) begin
            clr_addr <= clr_addr + aw'(1);
        end else begin
            clr_addr <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && (x == x_last) && (y == y_last);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_take;
        end
    end

    fb_ram #(
        .depth (depth),
        .aw    (aw)
    ) u_fb_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_take),
        .raddr (rd_addr),
        .rdata (rd_colour)
    );

endmodule

// File: tb/tb_pixel_framebuffer_rx.sv
// Directed self-checking bench for pixel_framebuffer_rx on an 8x4 frame.
module tb_pixel_framebuffer_rx;
    import pixel_pkg::*;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int XW = 4;
    localparam int YW = 3;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          plot      = 1'b0;
    logic [XW-1:0] x         = '0;
    logic [YW-1:0] y         = '0;
    colour_t       colour    = '0;
    logic          clear_req = 1'b0;
    logic          rd_en     = 1'b0;
    logic [XW-1:0] rd_x      = '0;
    logic [YW-1:0] rd_y      = '0;

    logic          ready;
    logic          frame_done;
    logic          rd_valid;
    colour_t       rd_colour;
    logic [15:0]   drop_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pixel_framebuffer_rx #(
        .horizontal (H),
        .vertical   (V)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .plot       (plot),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .clear_req  (clear_req),
        .ready      (ready),
        .frame_done (frame_done),
        .rd_en      (rd_en),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_valid   (rd_valid),
        .rd_colour  (rd_colour),
        .drop_cnt   (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_plot(input int cx, input int cy, input int c);
        x      = XW'(cx);
        y      = YW'(cy);
        colour = colour_t'(c);
        plot   = 1'b1;
        tick();
        plot   = 1'b0;
    endtask

    task automatic do_read(input int cx, input int cy);
        rd_x  = XW'(cx);
        rd_y  = YW'(cy);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic expect_pixel(input string tag, input int cx, input int cy, input int c);
        do_read(cx, cy);
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_colour"}, 32'(rd_colour), 32'(c));
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic expect_frame(input string tag, input int c);
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                expect_pixel($sformatf("%s_%0d_%0d", tag, xx, yy), xx, yy, c);
            end
        end
    endtask

    initial begin
        int n;
        logic seen_valid;

        // Reset state and power-on sweep length.
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_colour", 32'(rd_colour), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        reset = 1'b0;
        wait_ready(n);
        check("init_sweep_len", 32'(n), 32'd32);
        expect_frame("init", 0);

        // Single plot and address mapping.
        do_plot(3, 2, 5);
        check("pix_addr_3_2", pix_addr(32'd3, 32'd2, 32'd8), 32'd19);
        expect_pixel("nbr_2_2", 2, 2, 0);
        expect_pixel("nbr_4_2", 4, 2, 0);
        expect_pixel("nbr_3_1", 3, 1, 0);
        expect_pixel("plot_3_2", 3, 2, 5);
        tick();
        check("idle_rd_valid", 32'(rd_valid), 32'd0);
        check("idle_rd_hold", 32'(rd_colour), 32'd5);
        do_read(8, 0);
        check("oor_x_rd_valid", 32'(rd_valid), 32'd0);
        check("oor_x_rd_hold", 32'(rd_colour), 32'd5);
        do_read(0, 4);
        check("oor_y_rd_valid", 32'(rd_valid), 32'd0);
        check("oor_y_rd_hold", 32'(rd_colour), 32'd5);

        // Out-of-range plots are dropped and counted.
        do_plot(8, 0, 1);
        do_plot(0, 4, 1);
        check("drop_cnt_2", 32'(drop_cnt), 32'd2);
        expect_pixel("drop_0_0", 0, 0, 0);
        expect_pixel("drop_0_1", 0, 1, 0);
        expect_pixel("drop_keep_3_2", 3, 2, 5);
        x    = XW'(8);
        y    = '0;
        plot = 1'b1;
        repeat (65532) tick();
        check("drop_cnt_fffe", 32'(drop_cnt), 32'h0000FFFE);
        tick();
        check("drop_cnt_ffff", 32'(drop_cnt), 32'h0000FFFF);
        tick();
        check("drop_cnt_sat", 32'(drop_cnt), 32'h0000FFFF);
        plot = 1'b0;

        // Last-pixel pulse.
        do_plot(7, 3, 6);
        check("fd_pulse", 32'(frame_done), 32'd1);
        tick();
        check("fd_clear", 32'(frame_done), 32'd0);
        do_plot(6, 3, 1);
        check("fd_not_last", 32'(frame_done), 32'd0);
        expect_pixel("last_7_3", 7, 3, 6);
        x    = XW'(7);
        y    = YW'(3);
        plot = 1'b1;
        tick();
        check("fd_b2b_1", 32'(frame_done), 32'd1);
        tick();
        check("fd_b2b_2", 32'(frame_done), 32'd1);
        plot = 1'b0;
        tick();
        check("fd_b2b_end", 32'(frame_done), 32'd0);

        // Fill, then plot together with clear_req; plots during the sweep are ignored.
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                do_plot(xx, yy, 7);
            end
        end
        expect_pixel("fill_5_2", 5, 2, 7);
        x         = XW'(1);
        y         = YW'(1);
        colour    = colour_t'(2);
        plot      = 1'b1;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clr_ready_low", 32'(ready), 32'd0);
        colour = colour_t'(3);
        wait_ready(n);
        plot = 1'b0;
        check("clr_sweep_len", 32'(n), 32'd32);
        expect_frame("cleared", 0);

        // Reset in the middle of a sweep restarts it.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_rd_colour", 32'(rd_colour), 32'd0);
        check("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        reset = 1'b0;
        x     = XW'(8);
        y     = '0;
        plot  = 1'b1;
        rd_x  = '0;
        rd_y  = '0;
        rd_en = 1'b1;
        n          = 0;
        seen_valid = 1'b0;
        while (!ready && n < 200) begin
            tick();
            n++;
            seen_valid = seen_valid | rd_valid;
        end
        plot  = 1'b0;
        rd_en = 1'b0;
        check("rst_sweep_len", 32'(n), 32'd32);
        check("clear_rd_ignored", 32'(seen_valid), 32'd0);
        check("clear_drop_ignored", 32'(drop_cnt), 32'd0);

        // Same-cycle read and write to one address returns the old value.
        do_plot(2, 0, 3);
        x      = XW'(2);
        y      = '0;
        colour = colour_t'(4);
        plot   = 1'b1;
        rd_x   = XW'(2);
        rd_y   = '0;
        rd_en  = 1'b1;
        tick();
        plot  = 1'b0;
        rd_en = 1'b0;
        check("rw_same_valid", 32'(rd_valid), 32'd1);
        check("rw_same_old", 32'(rd_colour), 32'd3);
        expect_pixel("rw_after", 2, 0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
